// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants for the UART receive path.
//   PRESCALE_MIN / PRESCALE_MAX : legal oversampling ratio window; anything
//                                 outside is clamped into it
//   PRESCALE_W_DEF              : default width of prescale and edge counter
//   BIT_CNT_W_DEF               : default width of the bit-in-frame counter
//   FRAME_BITS_MAX              : start + 8 data + parity + stop
//   IDLE_LEVEL                  : level of an idle serial line
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int   PRESCALE_MIN   = 8;
  localparam int   PRESCALE_MAX   = 32;
  localparam int   PRESCALE_W_DEF = 6;
  localparam int   BIT_CNT_W_DEF  = 4;
  localparam int   FRAME_BITS_MAX = 11;
  localparam logic IDLE_LEVEL     = 1'b1;

  // Clamp a requested oversampling ratio into the supported window.
  function automatic logic [31:0] clampPrescale(input logic [31:0] requested);
    logic [31:0] result;
    result = requested;
    if (requested < 32'(PRESCALE_MIN)) begin
      result = 32'(PRESCALE_MIN);
    end else if (requested > 32'(PRESCALE_MAX)) begin
      result = 32'(PRESCALE_MAX);
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// ---------------------------------------------------------------------------
// edge_bit_counter
// Timing skeleton of the receiver: latches and clamps the oversampling ratio
// at the start of every frame, counts oversampling edges within a bit and
// bits within a frame, and flags the last edge of every bit.
// Ports:
//   i_clk       : system clock, rising edge
//   i_rstN      : synchronous active-low reset
//   i_cntEn     : counting enable, high for the whole frame
//   i_prescale  : requested oversampling ratio (sampled on the enable rise)
//   o_edgeCnt   : edge index within the current bit, 0..pre-1
//   o_bitCnt    : bit index within the frame, saturating
//   o_bitDone   : high in the last edge cycle of a bit
//   o_pre       : ratio in effect this cycle (used by the sampler for mid)
// ---------------------------------------------------------------------------
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_cntEn,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edgeCnt,
  output logic [BIT_CNT_W-1:0]  o_bitCnt,
  output logic                  o_bitDone,
  output logic [PRESCALE_W-1:0] o_pre
);

  logic                  r_enPrev;
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] r_edgeCnt;
  logic [BIT_CNT_W-1:0]  r_bitCnt;

  logic                  w_start;
  logic [PRESCALE_W-1:0] w_preClamped;
  logic [PRESCALE_W-1:0] w_pre;
  logic                  w_lastEdge;
  logic                  w_bitCntFull;

  // The first enabled cycle of a frame uses the freshly clamped request
  // directly, so decoding never sees a stale ratio from the previous frame.
  assign w_start      = i_cntEn & ~r_enPrev;
  assign w_preClamped = PRESCALE_W'(clampPrescale(32'(i_prescale)));
  assign w_pre        = w_start ? w_preClamped : r_pre;
  assign w_lastEdge   = (r_edgeCnt == (w_pre - PRESCALE_W'(1)));
  assign w_bitCntFull = (r_bitCnt == {BIT_CNT_W{1'b1}});

  // Counters restart from zero whenever the enable is low, and the bit
  // counter sticks at all-ones instead of wrapping on over-long frames.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_enPrev  <= 1'b0;
      r_pre     <= PRESCALE_W'(PRESCALE_MIN);
      r_edgeCnt <= '0;
      r_bitCnt  <= '0;
    end else begin
      r_enPrev <= i_cntEn;
      if (w_start) begin
        r_pre <= w_preClamped;
      end
      if (i_cntEn) begin
        if (w_lastEdge) begin
          r_edgeCnt <= '0;
          if (!w_bitCntFull) begin
            r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
          end
        end else begin
          r_edgeCnt <= r_edgeCnt + PRESCALE_W'(1);
        end
      end else begin
        r_edgeCnt <= '0;
        r_bitCnt  <= '0;
      end
    end
  end

  assign o_edgeCnt = r_edgeCnt;
  assign o_bitCnt  = r_bitCnt;
  assign o_bitDone = i_cntEn & w_lastEdge;
  assign o_pre     = w_pre;

endmodule

// File: rtl/rx_data_sampler.sv
// ---------------------------------------------------------------------------
// rx_data_sampler
// Oversampling front end of the UART receiver. Takes three samples of the
// serial line around the centre of every bit and publishes their majority
// vote once per bit period, together with the edge/bit timing.
// Ports:
//   CLK          : system clock, rising edge
//   RST          : synchronous active-low reset
//   cnt_en       : counting/sampling enable from the RX controller
//   prescale     : oversampling ratio, legal 8..32 (clamped otherwise)
//   RX_IN        : serial line, already synchronous to CLK
//   edge_cnt     : edge index within the current bit
//   bit_cnt      : bit index within the frame
//   bit_done     : high in the last edge cycle of a bit
//   sampled_bit  : majority-voted value of the current bit
//   sample_valid : one-cycle pulse when sampled_bit was just updated
// ---------------------------------------------------------------------------
module rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cnt_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  RX_IN,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic [PRESCALE_W-1:0] w_edgeCnt;
  logic [PRESCALE_W-1:0] w_pre;
  logic [PRESCALE_W-1:0] w_mid;
  logic [PRESCALE_W-1:0] w_midM1;
  logic [PRESCALE_W-1:0] w_midP1;
  logic                  w_vote;

  logic                  r_s0;
  logic                  r_s1;
  logic                  r_sampledBit;
  logic                  r_sampleValid;

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edgeBitCounter (
    .i_clk      (CLK),
    .i_rstN     (RST),
    .i_cntEn    (cnt_en),
    .i_prescale (prescale),
    .o_edgeCnt  (w_edgeCnt),
    .o_bitCnt   (bit_cnt),
    .o_bitDone  (bit_done),
    .o_pre      (w_pre)
  );

  // Sample points sit one edge either side of the (floored) bit centre.
  // With pre >= 8 all three lie well inside the bit, as does the pulse
  // that follows the vote.
  assign w_mid   = w_pre >> 1;
  assign w_midM1 = w_mid - PRESCALE_W'(1);
  assign w_midP1 = w_mid + PRESCALE_W'(1);

  // Third vote sample is taken live from the line in the mid+1 cycle.
  assign w_vote = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);

  // Capture the two early samples, then vote on the third. Dropping the
  // enable discards partial samples but keeps the last published bit so
  // downstream stages still see a stable value.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_s0          <= IDLE_LEVEL;
      r_s1          <= IDLE_LEVEL;
      r_sampledBit  <= IDLE_LEVEL;
      r_sampleValid <= 1'b0;
    end else begin
      r_sampleValid <= 1'b0;
      if (!cnt_en) begin
        r_s0 <= IDLE_LEVEL;
        r_s1 <= IDLE_LEVEL;
      end else begin
        if (w_edgeCnt == w_midM1) begin
          r_s0 <= RX_IN;
        end
        if (w_edgeCnt == w_mid) begin
          r_s1 <= RX_IN;
        end
        if (w_edgeCnt == w_midP1) begin
          r_sampledBit  <= w_vote;
          r_sampleValid <= 1'b1;
        end
      end
    end
  end

  assign edge_cnt     = w_edgeCnt;
  assign sampled_bit  = r_sampledBit;
  assign sample_valid = r_sampleValid;

endmodule

// File: tb/tb_rx_data_sampler.sv
// ---------------------------------------------------------------------------
// tb_rx_data_sampler
// Drives directed frames followed by random traffic into rx_data_sampler and
// compares every output, every cycle, against a frame-level reference model
// that tracks elapsed cycles since the enable rose and the line history of
// the current bit.
// ---------------------------------------------------------------------------
module tb_rx_data_sampler;

  logic       CLK;
  logic       RST;
  logic       cnt_en;
  logic [5:0] prescale;
  logic       RX_IN;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       bit_done;
  logic       sampled_bit;
  logic       sample_valid;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int   mT       = 0;
  int   mPre     = 8;
  logic mSampled = 1'b1;
  logic mValid   = 1'b0;
  bit   mKnown   = 1'b0;
  logic hist [0:63];

  rx_data_sampler #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cnt_en       (cnt_en),
    .prescale     (prescale),
    .RX_IN        (RX_IN),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .bit_done     (bit_done),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic int clampRef(input int p);
    if (p < 8)  return 8;
    if (p > 32) return 32;
    return p;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check the outputs
  // of this cycle against the model, then advance the model across the
  // next rising edge.
  task automatic applyStimulus(input logic rstN, input logic en, input int pre, input logic rx);
    int   curPre;
    int   expEdge;
    int   expBit;
    int   e;
    int   mid;
    logic a;
    logic b;
    logic c;
    @(negedge CLK);
    RST      = rstN;
    cnt_en   = en;
    prescale = 6'(pre);
    RX_IN    = rx;
    #1;
    if (mKnown) begin
      curPre  = (mT == 0) ? clampRef(int'(prescale)) : mPre;
      expEdge = mT % curPre;
      expBit  = mT / curPre;
      if (expBit > 15) expBit = 15;
      checkOutput("edge_cnt", int'(edge_cnt), expEdge);
      checkOutput("bit_cnt", int'(bit_cnt), expBit);
      checkOutput("bit_done", int'(bit_done), (en && expEdge == curPre - 1) ? 1 : 0);
      checkOutput("sampled_bit", int'(sampled_bit), int'(mSampled));
      checkOutput("sample_valid", int'(sample_valid), int'(mValid));
    end
    if (!rstN) begin
      mT       = 0;
      mSampled = 1'b1;
      mValid   = 1'b0;
      mKnown   = 1'b1;
    end else if (en) begin
      if (mT == 0) mPre = clampRef(int'(prescale));
      e       = mT % mPre;
      mid     = mPre / 2;
      hist[e] = rx;
      mValid  = 1'b0;
      if (e == mid + 1) begin
        a        = hist[mid - 1];
        b        = hist[mid];
        c        = hist[mid + 1];
        mSampled = (int'(a) + int'(b) + int'(c) >= 2) ? 1'b1 : 1'b0;
        mValid   = 1'b1;
      end
      mT++;
    end else begin
      mT     = 0;
      mValid = 1'b0;
    end
  endtask

  initial begin
    logic randEn;
    logic randRx;
    logic randRst;
    int   randPre;

    RST      = 1'b0;
    cnt_en   = 1'b0;
    prescale = 6'd8;
    RX_IN    = 1'b1;
    $display("[TB] starting rx_data_sampler bench");

    // Reset, then confirm idle values
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8, 1'b1);
    applyStimulus(1'b1, 1'b0, 8, 1'b1);

    // pre = 8, ten bits of constant low
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b1, 8, 1'b0);
    for (int i = 0; i < 2; i++)  applyStimulus(1'b1, 1'b0, 8, 1'b1);

    // pre = 16, single-cycle glitch at the centre is outvoted
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 16, ((i % 16) == 8) ? 1'b0 : 1'b1);
    applyStimulus(1'b1, 1'b0, 16, 1'b1);

    // pre = 16, two low samples win the vote
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 16, ((i % 16) == 7 || (i % 16) == 8) ? 1'b0 : 1'b1);
    applyStimulus(1'b1, 1'b0, 16, 1'b1);

    // Clamping and mid-frame prescale changes
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 4, 1'b0);
    applyStimulus(1'b1, 1'b0, 4, 1'b1);
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b1, (i < 10) ? 40 : 10, i[3]);
    applyStimulus(1'b1, 1'b0, 10, 1'b1);
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1, 10, 1'b1);
    applyStimulus(1'b1, 1'b0, 10, 1'b1);

    // Enable dropped before the vote point
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 16, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16, 1'b0);

    // Reset in the middle of a pre = 32 frame, enable held through release
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, 32, 1'b0);
    applyStimulus(1'b0, 1'b1, 32, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 12, 1'b0);
    applyStimulus(1'b1, 1'b0, 12, 1'b1);

    // Random traffic
    randEn  = 1'b0;
    randRx  = 1'b1;
    randPre = 16;
    for (int i = 0; i < 5000; i++) begin
      if (randEn) begin
        if ($urandom_range(0, 199) == 0) randEn = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        randEn = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) randRx = ~randRx;
      if ($urandom_range(0, 9) == 0) randPre = int'($urandom_range(0, 63));
      randRst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      applyStimulus(randRst, randEn, randPre, randRx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rx_data_sampler.md
# rx_data_sampler

Oversampling front end of the UART receiver. It counts oversampling edges and bit periods while the RX controller enables it, and takes three samples of the serial line around each bit centre. A majority vote of those samples produces one `sampled_bit` per bit period. The result feeds the start, parity, stop-check and deserializer stages, each of which qualifies it with its own enable.

## Interface
Parameters:
- `PRESCALE_W`, default 6: width of the `prescale` input and of `edge_cnt`.
- `BIT_CNT_W`, default 4: width of `bit_cnt`; covers start + 8 data + parity + stop.

Ports:
- `CLK`, input, 1: system clock; all logic on the rising edge.
- `RST`, input, 1: reset, synchronous and active-low.
- `cnt_en`, input, 1: counting/sampling enable from the RX controller; high for the whole frame.
- `prescale`, input, `PRESCALE_W`: oversampling ratio; legal range 8..32.
- `RX_IN`, input, 1: serial line, already synchronous to `CLK` (synchronizer lives in the RX top).
- `edge_cnt`, output, `PRESCALE_W`: oversampling edge index within the current bit, 0..pre-1.
- `bit_cnt`, output, `BIT_CNT_W`: index of the current bit within the frame.
- `bit_done`, output, 1: high in the last edge cycle of a bit.
- `sampled_bit`, output, 1: majority-voted value of the current bit.
- `sample_valid`, output, 1: one-cycle pulse when `sampled_bit` has just been updated.

## Operation
- **Effective prescale (`pre`)**
  - Latched into an internal register on the first cycle `cnt_en` is high after being low (or after reset).
  - Values below 8 are clamped to 8; values above 32 are clamped to 32.
  - Changes to `prescale` while `cnt_en` stays high are ignored until the next rising `cnt_en`.
- **Centre point:** `mid = pre >> 1`. Odd `pre` is legal and uses the floor.
- **Edge counter**
  - While `cnt_en` = 1: next `edge_cnt` = 0 if `edge_cnt == pre-1`, otherwise `edge_cnt + 1`.
  - While `cnt_en` = 0: next `edge_cnt` = 0.
- **Bit counter**
  - Increments on each wrap of `edge_cnt` and saturates at all-ones.
  - Next value is 0 whenever `cnt_en` = 0.
- **`bit_done`** = `cnt_en && edge_cnt == pre-1`, decoded from registers; no combinational path from `RX_IN`.
- **Sampling**
  - `RX_IN` is captured into `s0` at the edge ending cycle `edge_cnt == mid-1`, and into `s1` at the edge ending cycle `edge_cnt == mid`.
  - At the edge ending cycle `edge_cnt == mid+1`, `sampled_bit` <= maj(`s0`, `s1`, `RX_IN`) and `sample_valid` <= 1.
  - `sample_valid` is 0 in every other cycle.
- **Disable mid-bit**
  - If `cnt_en` falls before the `mid+1` cycle, no `sample_valid` pulse occurs for that bit.
  - `s0`/`s1` are cleared.
  - `sampled_bit` holds its last value.
- **Reset values:** `edge_cnt` = 0, `bit_cnt` = 0, `bit_done` = 0, `sample_valid` = 0, `s0`/`s1` = 1, latched `pre` = 8, `sampled_bit` = 1 (idle line level).

## Timing
- First cycle with `cnt_en` = 1 has `edge_cnt` = 0 and `bit_cnt` = 0.
- `sample_valid` is high in the cycle where `edge_cnt == mid+2`. For all legal `pre`, `mid+2 <= pre-1`, so the pulse always lands inside the same bit.
- Latency from the last vote sample to `sampled_bit` valid: 1 cycle.
- `bit_done` and the `edge_cnt` wrap coincide. `bit_cnt` shows the new value one cycle after `bit_done`.
- Per bit: exactly one `sample_valid` and one `bit_done`, `pre` cycles apart.
- Simultaneous `cnt_en` deassert and `edge_cnt == mid+1`: no update, since the update is gated by `cnt_en`.
- Reset asserted mid-frame: all state returns to reset values at the next edge. Counting restarts only on a fresh `cnt_en` rise, with `pre` re-latched.

## Structure
- Shared package `uart_rx_pkg`:
  - `PRESCALE_MIN` = 8 and `PRESCALE_MAX` = 32.
  - Default `PRESCALE_W`/`BIT_CNT_W`.
  - `FRAME_BITS_MAX` = 11.
  - Idle line level constant.
- Natural sub-module: `edge_bit_counter`, which holds the prescale latch/clamp, `edge_cnt`, `bit_cnt` and `bit_done`. The vote/sample logic stays in the parent.
- The 3-input majority is inline logic; no separate module.

## Test plan
- `pre` = 8, `cnt_en` high for 10 bit periods, `RX_IN` = 0 constant:
  - `edge_cnt` sequence 0..7 repeating, `bit_done` every 8th cycle.
  - `bit_cnt` 0..9; `sample_valid` at `edge_cnt` = 6 with `sampled_bit` = 0.
- `pre` = 16, `RX_IN` high except a 1-cycle low at `edge_cnt` = 8 → `sampled_bit` = 1 (glitch outvoted), `sample_valid` at `edge_cnt` = 10.
- `pre` = 16, `RX_IN` low during `edge_cnt` = 7 and 8, high elsewhere → `sampled_bit` = 0.
- `prescale` = 4 → behaves as 8; `prescale` = 40 → `edge_cnt` wraps at 31. A `prescale` change mid-frame has no effect until `cnt_en` re-rises.
- `cnt_en` dropped at `edge_cnt` = 5 with `pre` = 16 → no `sample_valid`, counters 0 next cycle, `sampled_bit` unchanged.
- `RST` low mid-frame (`pre` = 32, `bit_cnt` = 3) → next cycle all outputs at reset values (`sampled_bit` = 1). `cnt_en` held high through release restarts from `edge_cnt` = 0 with `pre` re-latched.
